// File: rtl/conv3x3_mac_relu.sv
// 3x3 convolution engine: runtime-loaded signed kernel and bias, four-stage MAC
// pipeline, then round / shift / ReLU / saturate to one unsigned pixel per window.
module conv3x3_mac_relu #(
   parameter int DATA_WIDHT   = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACC_WIDTH    = 24,
   parameter int SHIFT        = 6
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           Load_Start,
   input  logic signed [ACC_WIDTH-1:0]    Bias_In,
   input  logic signed [WEIGHT_WIDTH-1:0] Weight_In,
   input  logic                           Weight_Valid,
   input  logic [DATA_WIDHT-1:0]          Data_In1,
   input  logic [DATA_WIDHT-1:0]          Data_In2,
   input  logic [DATA_WIDHT-1:0]          Data_In3,
   input  logic [DATA_WIDHT-1:0]          Data_In4,
   input  logic [DATA_WIDHT-1:0]          Data_In5,
   input  logic [DATA_WIDHT-1:0]          Data_In6,
   input  logic [DATA_WIDHT-1:0]          Data_In7,
   input  logic [DATA_WIDHT-1:0]          Data_In8,
   input  logic [DATA_WIDHT-1:0]          Data_In9,
   input  logic                           Valid_In,
   output logic [DATA_WIDHT-1:0]          Data_Out,
   output logic                           Valid_Out,
   output logic                           Weights_Ready,
   output logic                           Drop_Err
);
   localparam int PW = WEIGHT_WIDTH + DATA_WIDHT + 1;
   localparam logic signed [ACC_WIDTH-1:0] RND     = ACC_WIDTH'((2 ** SHIFT) / 2);
   localparam logic signed [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'((2 ** DATA_WIDHT) - 1);

   typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

   state_t                         state_q;
   logic [3:0]                     cnt_q;
   logic signed [WEIGHT_WIDTH-1:0] w_q [9];
   logic signed [ACC_WIDTH-1:0]    bias_q;
   logic                           rdy_q;
   logic                           drop_q;

   logic [DATA_WIDHT-1:0]          pix [9];
   logic signed [PW-1:0]           prod_d [9];
   logic                           accept;

   logic signed [PW-1:0]           prod_p1 [9];
   logic signed [ACC_WIDTH-1:0]    bias_p1, bias_p2;
   logic signed [ACC_WIDTH-1:0]    psum_p2 [3];
   logic signed [ACC_WIDTH-1:0]    sum_p3;
   logic                           vld_p1, vld_p2, vld_p3;
   logic [DATA_WIDHT-1:0]          data_q;
   logic                           valid_q;

   function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [PW-1:0] p);
      return ACC_WIDTH'(p);
   endfunction

   function automatic logic [DATA_WIDHT-1:0] requant(input logic signed [ACC_WIDTH-1:0] s);
      logic signed [ACC_WIDTH-1:0] r;
      r = (s + RND) >>> SHIFT;
      if (r[ACC_WIDTH-1])  return '0;
      else if (r > PIX_MAX) return '1;
      else                  return r[DATA_WIDHT-1:0];
   endfunction

   always_comb begin
      pix[0] = Data_In1; pix[1] = Data_In2; pix[2] = Data_In3;
      pix[3] = Data_In4; pix[4] = Data_In5; pix[5] = Data_In6;
      pix[6] = Data_In7; pix[7] = Data_In8; pix[8] = Data_In9;
      for (int k = 0; k < 9; k++)
         prod_d[k] = PW'(w_q[k]) * PW'($signed({1'b0, pix[k]}));
   end

   assign accept = Valid_In && (state_q == READY);

   // Kernel load FSM; Load_Start takes priority over any weight beat in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         cnt_q   <= '0;
         bias_q  <= '0;
         rdy_q   <= 1'b0;
         drop_q  <= 1'b0;
         for (int k = 0; k < 9; k++) w_q[k] <= '0;
      end else begin
         if (Valid_In && state_q != READY) drop_q <= 1'b1;
         if (Load_Start) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            bias_q  <= Bias_In;
            rdy_q   <= 1'b0;
         end else if (state_q == LOAD && Weight_Valid) begin
            w_q[cnt_q] <= Weight_In;
            if (cnt_q == 4'd8) begin
               state_q <= READY;
               rdy_q   <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 4'd1;
            end
         end
      end
   end

   // Valid chain and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         vld_p3  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         vld_p1  <= accept;
         vld_p2  <= vld_p1;
         vld_p3  <= vld_p2;
         valid_q <= vld_p3;
         if (vld_p3) data_q <= requant(sum_p3);
      end
   end

   // Datapath; bias travels with the window so a reload never corrupts in-flight work
   always_ff @(posedge clk) begin
      // stage 1: products
      if (accept) begin
         prod_p1 <= prod_d;
         bias_p1 <= bias_q;
      end
      // stage 2: row partial sums
      if (vld_p1) begin
         for (int j = 0; j < 3; j++)
            psum_p2[j] <= sext(prod_p1[3*j]) + sext(prod_p1[3*j+1]) + sext(prod_p1[3*j+2]);
         bias_p2 <= bias_p1;
      end
      // stage 3: final sum plus bias
      if (vld_p2) sum_p3 <= psum_p2[0] + psum_p2[1] + psum_p2[2] + bias_p2;
   end

   assign Data_Out      = data_q;
   assign Valid_Out     = valid_q;
   assign Weights_Ready = rdy_q;
   assign Drop_Err      = drop_q;
endmodule
